// File: rtl/serial_digit_adder.sv
// Digit-serial adder: adds A+B+Cin DIGIT bits per clock through one slice and a registered carry.
// Define SERIAL_ADDER_OVERFLOW_EN to add the registered signed-overflow output V.
module serial_digit_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef SERIAL_ADDER_OVERFLOW_EN
  ,
  output logic             V
`endif
);

  // state | meaning
  // IDLE  | waiting for start, Sum/Cout hold last result
  // RUN   | one digit slice added per clock
  localparam int NSTEP = WIDTH / DIGIT;
  localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic [DIGIT:0]   slice;
  logic [WIDTH-1:0] dig_w;
  logic [WIDTH-1:0] acc_next;

  assign slice    = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
  assign dig_w    = WIDTH'(slice[DIGIT-1:0]);
  // New digit enters from the MSB end so after NSTEP shifts the LSB digit sits at bit 0.
  assign acc_next = (acc >> DIGIT) | (dig_w << (WIDTH - DIGIT));

`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic v_next;
  // Carry into the MSB is recovered as a^b^sum of that bit, avoiding a split slice.
  assign v_next = a_sh[DIGIT-1] ^ b_sh[DIGIT-1] ^ slice[DIGIT-1] ^ slice[DIGIT];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      Sum   <= '0;
      Cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      acc   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      V     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= A;
            b_sh  <= B;
            carry <= Cin;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          acc   <= acc_next;
          carry <= slice[DIGIT];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(NSTEP - 1)) begin
            Sum   <= acc_next;
            Cout  <= slice[DIGIT];
`ifdef SERIAL_ADDER_OVERFLOW_EN
            V     <= v_next;
`endif
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_digit_adder.sv
// Self-checking bench for serial_digit_adder: cycle model on the 16/4 instance plus parameter sweeps.
`timescale 1ns/1ps
module tb_serial_digit_adder;
  localparam int W = 16;
  localparam int D = 4;
  localparam int NSTEP = W / D;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         rst_s = 1'b0;
  logic         start = 1'b0;
  logic         Cin = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         busy, done, Cout;
  logic [W-1:0] Sum;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         V;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_digit_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .Sum(Sum), .Cout(Cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
    , .V(V)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: the result is plain A+B+Cin, published NSTEP edges after acceptance.
  int         rem = 0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_v = 1'b0, m_pv = 1'b0;
  logic [W:0] m_pend = '0, m_res = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0; m_busy = 1'b0; m_done = 1'b0; m_res = '0; m_v = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        rem--;
        if (rem == 0) begin
          m_busy = 1'b0; m_done = 1'b1; m_res = m_pend; m_v = m_pv;
        end
      end else if (start) begin
        m_pend = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, Cin};
        m_pv   = (A[W-1] == B[W-1]) && (m_pend[W-1] != A[W-1]);
        rem    = NSTEP;
        m_busy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("sum",  32'(Sum),  32'(m_res[W-1:0]));
      check("cout", 32'(Cout), 32'(m_res[W]));
`ifdef SERIAL_ADDER_OVERFLOW_EN
      check("v", 32'(V), 32'(m_v));
`endif
    end
  end

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    @(negedge clk);
    A = a; B = b; Cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge after the accepting edge; lat = edges since acceptance when done is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      fails++;
      $display("FAIL done_timeout: no done within 40 cycles");
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] es, input logic ec, input string nm);
    int lat;
    drive(a, b, c);
    wait_done(lat);
    check({nm, "_lat"},  32'(lat),  32'(NSTEP));
    check({nm, "_sum"},  32'(Sum),  32'(es));
    check({nm, "_cout"}, 32'(Cout), 32'(ec));
  endtask

  // Parameter sweep instances: bit-serial 16/1, single-step 16/16, and 8/2.
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int SW = (g == 2) ? 8 : 16;
    localparam int SD = (g == 0) ? 1 : ((g == 1) ? 16 : 2);
    localparam int SN = SW / SD;
    logic          s_start = 1'b0, s_cin = 1'b0, s_busy, s_done, s_cout;
    logic [SW-1:0] s_a = '0, s_b = '0, s_sum;
    logic          fin = 1'b0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
    logic          s_v;
`endif

    serial_digit_adder #(.WIDTH(SW), .DIGIT(SD)) u_dut (
      .clk(clk), .rst_n(rst_s), .start(s_start), .A(s_a), .B(s_b), .Cin(s_cin),
      .busy(s_busy), .done(s_done), .Sum(s_sum), .Cout(s_cout)
`ifdef SERIAL_ADDER_OVERFLOW_EN
      , .V(s_v)
`endif
    );

    initial begin
      logic [SW:0] exp;
      int lat;
      @(posedge rst_s);
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        s_a = SW'($urandom); s_b = SW'($urandom); s_cin = 1'($urandom); s_start = 1'b1;
        exp = {1'b0, s_a} + {1'b0, s_b} + {{SW{1'b0}}, s_cin};
        @(negedge clk);
        s_start = 1'b0;
        lat = 0;
        while (!s_done && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        check($sformatf("sw%0d_lat", g),  32'(lat),    32'(SN));
        check($sformatf("sw%0d_sum", g),  32'(s_sum),  32'(exp[SW-1:0]));
        check($sformatf("sw%0d_cout", g), 32'(s_cout), 32'(exp[SW]));
      end
      fin = 1'b1;
    end
  end

  initial begin
    int lat;
    int guard;
    #1 rst_n = 1'b0;
    #11 rst_s = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(Sum),  32'd0);
    check("rst_cout", 32'(Cout), 32'd0);
    rst_n = 1'b1;

    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "op1");
    do_op(16'h0FFF, 16'h0000, 1'b1, 16'h1000, 1'b0, "carry1");
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "carry2");

    // start during RUN must be ignored; start in the done cycle is accepted
    drive(16'h1111, 16'h2222, 1'b0);
    @(negedge clk);
    A = 16'hFFFF; B = 16'hFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("ign_sum",  32'(Sum),  32'h3333);
    check("ign_cout", 32'(Cout), 32'd0);
    A = 16'h0001; B = 16'h0002; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    check("b2b_lat", 32'(lat), 32'(NSTEP));
    check("b2b_sum", 32'(Sum), 32'h0003);

    // asynchronous reset in the middle of a run
    drive(16'h1234, 16'h1111, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_sum",  32'(Sum),  32'd0);
    check("arst_cout", 32'(Cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "post_rst");

`ifdef SERIAL_ADDER_OVERFLOW_EN
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, "ov1");
    check("ov1_v", 32'(V), 32'd1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "ov2");
    check("ov2_v", 32'(V), 32'd0);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "ov3");
    check("ov3_v", 32'(V), 32'd1);
`endif

    guard = 0;
    while (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin) && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (!(g_sw[0].fin && g_sw[1].fin && g_sw[2].fin)) begin
      fails++;
      $display("FAIL sweep_timeout: sweeps did not finish");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
